// File: rtl/insn_encode_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : insn_encode_pkg                                            |
// | Description : MIPS instruction-format constants, field positions and the |
// |               word-packing helper used by the encoder. The decode stage  |
// |               imports the same constants so the two cannot drift apart.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package insn_encode_pkg;

  typedef enum logic [1:0] {
    INSN_R   = 2'd0,
    INSN_I   = 2'd1,
    INSN_J   = 2'd2,
    INSN_ILL = 2'd3
  } insn_type_e;

  // Field bit positions inside a 32-bit MIPS word
  localparam int OP_MSB = 31;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shift_amount;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] j_address;
  } insn_fields_t;

  // Fields that a format does not use are simply not placed into the word.
  // The illegal type packs to zero; callers never store it.
  function automatic logic [31:0] pack_insn(input insn_type_e t, input insn_fields_t f);
    logic [31:0] w;
    w = '0;
    case (t)
      INSN_R: begin
        w[OP_MSB -: 6] = OP_RTYPE;
        w[RS_LSB +: 5] = f.rs;
        w[RT_LSB +: 5] = f.rt;
        w[RD_LSB +: 5] = f.rd;
        w[SH_LSB +: 5] = f.shift_amount;
        w[5:0]         = f.funct;
      end
      INSN_I: begin
        w[OP_MSB -: 6] = f.opcode;
        w[RS_LSB +: 5] = f.rs;
        w[RT_LSB +: 5] = f.rt;
        w[15:0]        = f.immediate;
      end
      INSN_J: begin
        w[OP_MSB -: 6] = f.opcode;
        w[25:0]        = f.j_address;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/insn_encode_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : insn_fifo                                                  |
// | Description : Synchronous FIFO, power-of-two depth, registered occupancy |
// |               count. Push while full is allowed only together with a pop.|
// |               Ports: clock, reset_n (async low), push/push_data,         |
// |               pop/pop_data (head, valid when !empty), full, empty, count.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module insn_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full_cnt = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != c_full_cnt) | w_do_pop);

  // Storage carries no reset; only the pointers/count define validity.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == c_full_cnt);
  assign empty    = (r_count == '0);
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/insn_encode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : insn_encode                                                |
// | Description : Packs instruction fields into 32-bit MIPS words and streams|
// |               them with byte addresses to the instruction-memory write   |
// |               port through an elastic FIFO.                              |
// |   clock, reset_n      : clock, asynchronous active-low reset             |
// |   in_valid/in_ready   : field-bundle handshake                           |
// |   insn_type, opcode, rs, rt, rd, shift_amount, funct, immediate,         |
// |   j_address           : instruction fields                               |
// |   out_valid/out_ready : word handshake; out_insn, out_addr payload       |
// |   err_illegal         : sticky illegal-type flag                         |
// |   words_sent          : saturating count of delivered words              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module insn_encode
  import insn_encode_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        insn_type,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shift_amount,
  input  logic [5:0]        funct,
  input  logic [15:0]       immediate,
  input  logic [25:0]       j_address,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_insn,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_illegal,
  output logic [15:0]       words_sent
);

  localparam logic [ADDR_W-1:0]          c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]          c_word_step = ADDR_W'(4);
  localparam logic [$clog2(DEPTH):0]     c_depth_cnt = ($clog2(DEPTH)+1)'(DEPTH);

  insn_fields_t              w_fields;
  logic [31:0]               w_packed;
  logic                      w_is_ill;
  logic                      w_accept;
  logic                      w_push;
  logic                      w_pop;
  logic [31:0]               w_head;
  logic                      w_full;
  logic                      w_empty;
  logic [$clog2(DEPTH):0]    w_count;
  logic [ADDR_W-1:0]         r_addr;
  logic                      r_err;
  logic [15:0]               r_words;

  assign w_fields = '{opcode:       opcode,
                      rs:           rs,
                      rt:           rt,
                      rd:           rd,
                      shift_amount: shift_amount,
                      funct:        funct,
                      immediate:    immediate,
                      j_address:    j_address};

  assign w_packed = pack_insn(insn_type_e'(insn_type), w_fields);
  assign w_is_ill = (insn_type_e'(insn_type) == INSN_ILL);

  // in_ready only looks at registered occupancy, never at out_ready; it is
  // also held low while reset is asserted.
  assign in_ready = ~w_full & reset_n;
  assign w_accept = in_valid & in_ready;
  // Illegal bundles are consumed but never reach the FIFO.
  assign w_push   = w_accept & ~w_is_ill;
  assign w_pop    = out_valid & out_ready;

  insn_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_packed),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= c_base_addr;
      r_err   <= 1'b0;
      r_words <= '0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + c_word_step;
        if (r_words != 16'hFFFF) begin
          r_words <= r_words + 16'd1;
        end
      end
      if (w_accept && w_is_ill) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_valid   = ~w_empty;
  // Stale storage is masked so the word bus reads zero when nothing is queued.
  assign out_insn    = w_empty ? 32'h0 : w_head;
  assign out_addr    = r_addr;
  assign err_illegal = r_err;
  assign words_sent  = r_words;

  a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
                                  (w_count <= c_depth_cnt));

endmodule
`default_nettype wire

// File: tb/tb_insn_encode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_insn_encode                                             |
// | Description : Self-checking bench for insn_encode: vector table of       |
// |               encodings plus directed back-pressure, illegal-type,       |
// |               full-FIFO streaming and mid-transfer reset sequences.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_insn_encode;

  typedef struct {
    logic [1:0]  t;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fu;
    logic [15:0] imm;
    logic [25:0] jad;
    logic [31:0] exp;
  } vec_t;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  insn_type;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shift_amount;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [25:0] j_address;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_addr;
  logic        err_illegal;
  logic [15:0] words_sent;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs [6];
  vec_t ill;

  insn_encode #(
    .DEPTH     (4),
    .ADDR_W    (32),
    .BASE_ADDR (32'h0)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .insn_type    (insn_type),
    .opcode       (opcode),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .shift_amount (shift_amount),
    .funct        (funct),
    .immediate    (immediate),
    .j_address    (j_address),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_insn     (out_insn),
    .out_addr     (out_addr),
    .err_illegal  (err_illegal),
    .words_sent   (words_sent)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic drive(input vec_t v);
    insn_type    = v.t;
    opcode       = v.op;
    rs           = v.rs;
    rt           = v.rt;
    rd           = v.rd;
    shift_amount = v.sh;
    funct        = v.fu;
    immediate    = v.imm;
    j_address    = v.jad;
  endtask

  task automatic push(input vec_t v);
    int g;
    @(negedge clock);
    drive(v);
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (!in_ready) fail_timeout("push");
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Independent decode of the output word against the source fields.
  task automatic roundtrip(input vec_t v, input logic [31:0] w);
    case (v.t)
      2'd0: begin
        check("rt R op", {26'd0, w[31:26]}, 32'd0);
        check("rt R rs", {27'd0, w[25:21]}, {27'd0, v.rs});
        check("rt R rt", {27'd0, w[20:16]}, {27'd0, v.rt});
        check("rt R rd", {27'd0, w[15:11]}, {27'd0, v.rd});
        check("rt R sh", {27'd0, w[10:6]},  {27'd0, v.sh});
        check("rt R fu", {26'd0, w[5:0]},   {26'd0, v.fu});
      end
      2'd1: begin
        check("rt I op",  {26'd0, w[31:26]}, {26'd0, v.op});
        check("rt I rs",  {27'd0, w[25:21]}, {27'd0, v.rs});
        check("rt I rt",  {27'd0, w[20:16]}, {27'd0, v.rt});
        check("rt I imm", {16'd0, w[15:0]},  {16'd0, v.imm});
      end
      default: begin
        check("rt J op",  {26'd0, w[31:26]}, {26'd0, v.op});
        check("rt J tgt", {6'd0, w[25:0]},   {6'd0, v.jad});
      end
    endcase
  endtask

  // Wait for a word, check it, then pop exactly that one word.
  task automatic expect_word(input vec_t v, input logic [31:0] addr, input string tag);
    int g;
    g = 0;
    @(negedge clock);
    while (!out_valid && g < 50) begin
      @(negedge clock);
      g++;
    end
    if (!out_valid) begin
      fail_timeout({tag, " out_valid"});
      return;
    end
    check({tag, " insn"}, out_insn, v.exp);
    check({tag, " addr"}, out_addr, addr);
    roundtrip(v, out_insn);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int   idx_in;
    int   idx_out;
    vec_t v;

    // ADD $3,$1,$2
    vecs[0] = '{t:2'd0, op:6'h00, rs:5'd1, rt:5'd2, rd:5'd3, sh:5'd0, fu:6'd32,
                imm:16'h0, jad:26'h0, exp:32'h00221820};
    // ADDI $5,$4,-1
    vecs[1] = '{t:2'd1, op:6'd8, rs:5'd4, rt:5'd5, rd:5'd0, sh:5'd0, fu:6'd0,
                imm:16'hFFFF, jad:26'h0, exp:32'h2085FFFF};
    // J 0x10
    vecs[2] = '{t:2'd2, op:6'd2, rs:5'd0, rt:5'd0, rd:5'd0, sh:5'd0, fu:6'd0,
                imm:16'h0, jad:26'h0000010, exp:32'h08000010};
    // R with a junk opcode and immediate that must be ignored
    vecs[3] = '{t:2'd0, op:6'h3F, rs:5'd31, rt:5'd0, rd:5'd31, sh:5'd31, fu:6'h3F,
                imm:16'hA5A5, jad:26'h3FFFFFF, exp:32'h03E0FFFF};
    // LW $7,0x1234($6)
    vecs[4] = '{t:2'd1, op:6'h23, rs:5'd6, rt:5'd7, rd:5'd9, sh:5'd3, fu:6'h11,
                imm:16'h1234, jad:26'h0, exp:32'h8CC71234};
    // JAL to all-ones target
    vecs[5] = '{t:2'd2, op:6'd3, rs:5'd5, rt:5'd5, rd:5'd5, sh:5'd5, fu:6'h5,
                imm:16'h5555, jad:26'h3FFFFFF, exp:32'h0FFFFFFF};
    ill     = '{t:2'd3, op:6'h3F, rs:5'd1, rt:5'd1, rd:5'd1, sh:5'd1, fu:6'h1,
                imm:16'h1, jad:26'h1, exp:32'h0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(vecs[0]);

    // Reset state, sampled while reset is held
    #2;
    check("rst out_valid",   {31'd0, out_valid},   32'd0);
    check("rst in_ready",    {31'd0, in_ready},    32'd0);
    check("rst out_insn",    out_insn,             32'd0);
    check("rst out_addr",    out_addr,             32'd0);
    check("rst err_illegal", {31'd0, err_illegal}, 32'd0);
    check("rst words_sent",  {16'd0, words_sent},  32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Table: one word in, one word out, addresses step by 4
    for (int i = 0; i < 6; i++) begin
      push(vecs[i]);
      expect_word(vecs[i], 32'(4 * i), $sformatf("vec%0d", i));
    end
    @(negedge clock);
    check("table words_sent", {16'd0, words_sent}, 32'd6);

    // Back-pressure: four fill the FIFO, fifth is held
    do_reset();
    for (int i = 0; i < 4; i++) push(vecs[i]);
    @(negedge clock);
    check("bp full in_ready", {31'd0, in_ready}, 32'd0);
    drive(vecs[4]);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp stall insn",      out_insn,             vecs[0].exp);
      check("bp stall addr",      out_addr,             32'd0);
      check("bp stall in_ready",  {31'd0, in_ready},    32'd0);
      check("bp stall out_valid", {31'd0, out_valid},   32'd1);
    end
    expect_word(vecs[0], 32'h0, "bp w0");
    @(posedge clock);
    #1 in_valid = 1'b0;
    for (int i = 1; i < 5; i++) expect_word(vecs[i], 32'(4 * i), $sformatf("bp w%0d", i));

    // Illegal bundle between two legal ones
    do_reset();
    push(vecs[0]);
    push(ill);
    push(vecs[1]);
    @(negedge clock);
    check("ill err set", {31'd0, err_illegal}, 32'd1);
    expect_word(vecs[0], 32'h0, "ill w0");
    expect_word(vecs[1], 32'h4, "ill w1");
    repeat (3) @(negedge clock);
    check("ill drained",    {31'd0, out_valid},   32'd0);
    check("ill words_sent", {16'd0, words_sent},  32'd2);
    check("ill err sticky", {31'd0, err_illegal}, 32'd1);

    // Full FIFO with producer and consumer both active: every word exactly once, in order
    do_reset();
    for (int i = 0; i < 4; i++) push(vecs[i]);
    out_ready = 1'b1;
    idx_in    = 4;
    idx_out   = 0;
    for (int cyc = 0; cyc < 60 && idx_out < 8; cyc++) begin
      @(negedge clock);
      if (idx_in < 8) begin
        v = vecs[idx_in % 6];
        drive(v);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        check($sformatf("stream w%0d insn", idx_out), out_insn, vecs[idx_out % 6].exp);
        check($sformatf("stream w%0d addr", idx_out), out_addr, 32'(4 * idx_out));
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
    end
    if (idx_out < 8) fail_timeout("stream");
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    check("stream drained",    {31'd0, out_valid},  32'd0);
    check("stream words_sent", {16'd0, words_sent}, 32'd8);

    // Reset with three words queued discards them
    do_reset();
    for (int i = 0; i < 4; i++) push(vecs[i]);
    expect_word(vecs[0], 32'h0, "mr w0");
    @(negedge clock);
    check("mr pre words_sent", {16'd0, words_sent}, 32'd1);
    check("mr pre out_valid",  {31'd0, out_valid},  32'd1);
    reset_n = 1'b0;
    #1;
    check("mr out_valid",  {31'd0, out_valid},  32'd0);
    check("mr in_ready",   {31'd0, in_ready},   32'd0);
    check("mr out_addr",   out_addr,            32'd0);
    check("mr words_sent", {16'd0, words_sent}, 32'd0);
    check("mr out_insn",   out_insn,            32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("mr after out_valid", {31'd0, out_valid}, 32'd0);
    push(vecs[2]);
    expect_word(vecs[2], 32'h0, "mr new");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
